// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state type, baud helper and ASCII control codes
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic [7:0] CR = 8'd13, ESC = 8'd27, DEL = 8'd127, SPACE = 8'd32;
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: received-byte bus from the UART receiver to its consumer
interface uart_rx_if;
  logic [7:0] data_out;
  logic data_ready;
  logic framing_error;
  logic busy;
  modport master(output data_out, data_ready, framing_error, busy);
  modport slave(input data_out, data_ready, framing_error, busy);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous inputs with a reset value
module sync_2ff #(
  parameter int W = 1,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, s} <= {RST_VAL, RST_VAL};
    else {q, s} <= {s, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 oversampling receiver, samples mid-bit and strobes each framed byte
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD = 115200
) (
  input logic clock100,
  input logic reset,
  input logic rx,
  uart_rx_if.master bus
);
  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shreg, shreg_n, data_n;
  logic armed, armed_n, ready_n, ferr_n, rx_s, stop_hit, glitch;
  sync_2ff #(.W(1), .RST_VAL(1'b1)) u_sync (.clk(clock100), .rst(reset), .d(rx), .q(rx_s));
  assign stop_hit = state == STOP && cnt == BIT_END;
  assign glitch = state == START && cnt == HALF_END && rx_s;
  assign bus.busy = state != IDLE && !stop_hit && !glitch;
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    idx_n = idx;
    shreg_n = shreg;
    data_n = bus.data_out;
    armed_n = armed;
    ready_n = 1'b0;
    ferr_n = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        armed_n = armed | rx_s;
        state_n = armed && !rx_s ? START : IDLE;
      end
      START: if (cnt == HALF_END) begin
        state_n = rx_s ? IDLE : DATA;
        cnt_n = '0;
        idx_n = '0;
      end
      DATA: if (cnt == BIT_END) begin
        shreg_n[idx] = rx_s;
        cnt_n = '0;
        idx_n = idx + 3'd1;
        state_n = idx == 3'd7 ? STOP : DATA;
      end
      STOP: if (stop_hit) begin
        // a low stop bit disarms until the line is seen idle again
        state_n = IDLE;
        ready_n = rx_s;
        ferr_n = !rx_s;
        armed_n = rx_s;
        data_n = rx_s ? shreg : bus.data_out;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock100 or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shreg <= '0;
      armed <= 1'b0;
      bus.data_out <= '0;
      bus.data_ready <= 1'b0;
      bus.framing_error <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shreg <= shreg_n;
      armed <= armed_n;
      bus.data_out <= data_n;
      bus.data_ready <= ready_n;
      bus.framing_error <= ferr_n;
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized 8N1 line driver with a frame-level reference model
`timescale 1ns/1ps
module tb_uart_rx;
  import uart_pkg::*;
  localparam int CLK_HZ = 10_000_000, BAUD = 100_000;
  localparam int CPB = CLK_HZ / BAUD, HALF = CPB / 2;
  localparam int LAT = 2 + HALF + 9 * CPB + 1;
  localparam real BIT_NS = 1.0e9 / BAUD;
  logic clk = 0, rst = 1, rx = 1;
  int cyc = 0, errors = 0, checks = 0;
  int n_dr = 0, n_fe = 0, n_long = 0, dr_cyc = 0, fe_cyc = 0;
  logic dr_prev = 0;
  logic [7:0] got_q[$], exp_q[$];
  logic [7:0] last_good = 0;
  bit model_armed = 0;
  uart_rx_if bus();
  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (.clock100(clk), .reset(rst), .rx(rx), .bus(bus));
  always #50 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (bus.data_ready) begin got_q.push_back(bus.data_out); n_dr++; dr_cyc = cyc; end
    if (bus.framing_error) begin n_fe++; fe_cyc = cyc; end
    if (bus.data_ready && dr_prev) n_long++;
    dr_prev = bus.data_ready;
  end
  initial begin
    #(200_000 * 100);
    $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end
  task automatic idle(input int n);
    rx = 1;
    repeat (n) @(posedge clk);
    #1;
    if (n >= 3) model_armed = 1;
  endtask
  task automatic align(output int p);
    @(posedge clk);
    #1;
    p = cyc;
  endtask
  // Model: a frame is delivered iff the line was idle beforehand and its stop bit is high.
  task automatic send_frame(input logic [7:0] b, input real bit_ns, input bit stop_ok, input bit rec);
    logic [9:0] f;
    f = {stop_ok, b, 1'b0};
    if (rec) begin
      if (model_armed && stop_ok) begin exp_q.push_back(b); last_good = b; end
      model_armed = model_armed && stop_ok;
    end
    for (int i = 0; i < 10; i++) begin rx = f[i]; #(bit_ns); end
  endtask
  task automatic test_reset;
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h expected 00", bus.data_out); end
    checks++; if (bus.data_ready !== 1'b0) begin errors++; $display("FAIL reset_data_ready: got %b expected 0", bus.data_ready); end
    checks++; if (bus.framing_error !== 1'b0) begin errors++; $display("FAIL reset_framing_error: got %b expected 0", bus.framing_error); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    @(posedge clk); #1 rst = 0;
    model_armed = 0; last_good = 0;
  endtask
  task automatic test_single;
    int p, n0;
    idle(20);
    n0 = n_dr;
    align(p);
    send_frame(8'h41, BIT_NS, 1, 1);
    @(negedge clk);
    checks++; if (n_dr - n0 !== 1) begin errors++; $display("FAIL single_pulses: got %0d expected 1", n_dr - n0); end
    checks++; if (dr_cyc < p + LAT || dr_cyc > p + LAT + 1) begin errors++; $display("FAIL single_latency: got %0d expected %0d", dr_cyc - p, LAT); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b expected 0", bus.busy); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL single_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL single_data: got %h expected %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask
  task automatic test_back_to_back;
    int p, n0, f0;
    logic [7:0] v[3];
    v = '{CR, ESC, DEL};
    idle(2 * CPB);
    n0 = n_dr; f0 = n_fe;
    align(p);
    for (int i = 0; i < 3; i++) send_frame(v[i], BIT_NS, 1, 1);
    idle(10);
    checks++; if (n_dr - n0 !== 3) begin errors++; $display("FAIL b2b_pulses: got %0d expected 3", n_dr - n0); end
    checks++; if (n_fe !== f0) begin errors++; $display("FAIL b2b_framing: got %0d expected %0d", n_fe, f0); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL b2b_data: got %h expected %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask
  task automatic test_glitch;
    int p, n0, f0;
    idle(20);
    n0 = n_dr; f0 = n_fe;
    align(p);
    rx = 0;
    repeat (30) @(posedge clk);
    #1 rx = 1;
    while (cyc < p + 1 + HALF) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_high: got %b expected 1 at t0+%0d", bus.busy, HALF - 1); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_low: got %b expected 0 at t0+%0d", bus.busy, HALF); end
    idle(2 * CPB);
    checks++; if (n_dr !== n0) begin errors++; $display("FAIL glitch_ready: got %0d expected %0d", n_dr, n0); end
    checks++; if (n_fe !== f0) begin errors++; $display("FAIL glitch_framing: got %0d expected %0d", n_fe, f0); end
  endtask
  task automatic test_framing;
    int p, n0, f0;
    idle(2 * CPB);
    n0 = n_dr; f0 = n_fe;
    align(p);
    send_frame(8'h55, BIT_NS, 0, 1);
    repeat (20 * CPB) @(posedge clk);
    @(negedge clk);
    checks++; if (n_fe - f0 !== 1) begin errors++; $display("FAIL fe_pulses: got %0d expected 1", n_fe - f0); end
    checks++; if (fe_cyc < p + LAT || fe_cyc > p + LAT + 1) begin errors++; $display("FAIL fe_latency: got %0d expected %0d", fe_cyc - p, LAT); end
    checks++; if (n_dr !== n0) begin errors++; $display("FAIL fe_no_ready: got %0d expected %0d", n_dr, n0); end
    checks++; if (bus.data_out !== last_good) begin errors++; $display("FAIL fe_data_kept: got %h expected %h", bus.data_out, last_good); end
    idle(2 * CPB);
    send_frame(8'h33, BIT_NS, 1, 1);
    idle(CPB);
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL fe_recover_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL fe_recover_data: got %h expected %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask
  task automatic test_reset_midframe;
    int p, n0;
    idle(2 * CPB);
    n0 = n_dr;
    align(p);
    fork
      send_frame(8'h96, BIT_NS, 1, 0);
      begin
        while (cyc < p + 2 + HALF + 4 * CPB + 30) @(negedge clk);
        rst = 1;
        #1;
        checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL rst_mid_data_out: got %h expected 00", bus.data_out); end
        checks++; if (bus.data_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_data_ready: got %b expected 0", bus.data_ready); end
        checks++; if (bus.framing_error !== 1'b0) begin errors++; $display("FAIL rst_mid_framing: got %b expected 0", bus.framing_error); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", bus.busy); end
      end
    join
    @(posedge clk); #1 rst = 0;
    model_armed = 0; last_good = 0;
    checks++; if (n_dr !== n0) begin errors++; $display("FAIL rst_mid_no_pulse: got %0d expected %0d", n_dr, n0); end
    idle(3 * CPB);
    send_frame(8'hA5, BIT_NS, 1, 1);
    idle(CPB);
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rst_mid_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL rst_mid_data: got %h expected %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask
  task automatic test_baud;
    real f[2];
    f = '{1.025, 0.975};
    for (int i = 0; i < 2; i++) begin
      idle(2 * CPB);
      send_frame(8'h3C, BIT_NS / f[i], 1, 1);
      idle(CPB);
      checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL baud_count[%0d]: got %0d expected 1", i, got_q.size()); end
      checks++; if (bus.data_out !== 8'h3C) begin errors++; $display("FAIL baud_data[%0d]: got %h expected 3c", i, bus.data_out); end
      got_q.delete(); exp_q.delete();
    end
  endtask
  task automatic test_random;
    real fac;
    for (int burst = 0; burst < 3; burst++) begin
      fac = 0.98 + $urandom_range(0, 40) / 1000.0;
      idle(2 * CPB + $urandom_range(0, CPB));
      for (int i = 0; i < 4; i++) begin
        send_frame(8'($urandom_range(0, 255)), BIT_NS / fac, 1, 1);
        if ($urandom_range(0, 1) == 1) idle($urandom_range(3, CPB));
      end
      idle(CPB);
    end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL rand_data: got %h expected %h", g, e); end
    end
    checks++; if (n_long !== 0) begin errors++; $display("FAIL ready_width: got %0d multi-cycle pulses expected 0", n_long); end
  endtask
  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_framing;
    test_reset_midframe;
    test_baud;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
